// File: rtl/tx_line_arbiter.sv
// tx_line_arbiter: shares the single UART_TX pin between tape, MIDI and UART serial sources
// Ports: clk_sys, reset (asynchronous, active-high);
//        src_tape / src_midi / src_uart : idle-high serial sources, synchronous to clk_sys;
//        tx_out    : registered pin drive (idle high);
//        owner     : current grant, 0 none / 1 tape / 2 midi / 3 uart;
//        busy      : registered, high while owner != 0;
//        collision : one-cycle pulse when a non-owner toggles while the pin is owned.
// Build option: define TXARB_RR_EN for round-robin selection among simultaneous
// toggles; otherwise fixed priority uart > midi > tape.
module tx_line_arbiter #(
    parameter int HOLD_CYCLES = 840000,
    parameter int CNT_W       = 20
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       src_tape,
    input  logic       src_midi,
    input  logic       src_uart,
    output logic       tx_out,
    output logic [1:0] owner,
    output logic       busy,
    output logic       collision
);
    typedef enum logic [1:0] {NONE, TAPE, MIDI, UART} state_t;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);
    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [3:0]       src, prev, act;
    logic [1:0]       win;
    logic             tx_nx, coll_nx, rel, grant;
    // lane 0 stands for "no owner": tied high so it never shows activity
    assign src   = {src_uart, src_midi, src_tape, 1'b1};
    assign act   = src ^ prev;
    assign rel   = state != NONE && cnt == '0 && src[state] && !act[state];
    assign grant = (state == NONE || rel) && win != 2'd0;
    assign owner = state;
`ifdef TXARB_RR_EN
    logic [1:0] rr_ptr, c0, c1, c2;
    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'd3) ? 2'd1 : p + 2'd1;
    endfunction
    // search starts one past the last granted source; pointer 0 behaves like 3
    assign c0  = rr_next(rr_ptr);
    assign c1  = rr_next(c0);
    assign c2  = rr_next(c1);
    assign win = act[c0] ? c0 : act[c1] ? c1 : act[c2] ? c2 : 2'd0;
    always_ff @(posedge clk_sys or posedge reset)
        if (reset)
            rr_ptr <= 2'd0;
        else if (grant)
            rr_ptr <= win;
`else
    assign win = act[3] ? 2'd3 : act[2] ? 2'd2 : act[1] ? 2'd1 : 2'd0;
`endif
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        tx_nx    = 1'b1;
        coll_nx  = 1'b0;
        if (grant) begin
            state_nx = state_t'(win);
            tx_nx    = src[win];
            cnt_nx   = RELOAD;
        end else if (rel) begin
            state_nx = NONE;
        end else if (state != NONE) begin
            tx_nx   = src[state];
            cnt_nx  = act[state] ? RELOAD : (cnt != '0 ? cnt - CNT_W'(1) : cnt);
            coll_nx = |(act & ~(4'b1 << state));
        end
    end
    always_ff @(posedge clk_sys or posedge reset)
        if (reset) begin
            state     <= NONE;
            cnt       <= '0;
            prev      <= '1;
            tx_out    <= 1'b1;
            busy      <= 1'b0;
            collision <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            prev      <= src;
            tx_out    <= tx_nx;
            busy      <= state_nx != NONE;
            collision <= coll_nx;
        end
endmodule
